echo_smoother: RTL and testbench

Filters raw ultrasonic echo pulse widths before they reach the inches display. It sits between the sensor's `echo_cycles` output and the display's `echo_width` input, in the 12 MHz HFOSC clock domain. It rejects out-of-range and timeout samples, and keeps a 4-deep ring buffer of good samples. It outputs their running average, together with a stale flag when the sensor stops returning usable echoes.

---
 rtl/echo_smoother.sv | 146 ++++++++++++++
 tb/tb_echo_smoother.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/echo_smoother.sv
// echo_smoother
// Cleans up raw ultrasonic echo widths before the inches display sees them.
// Samples outside [MIN_CYCLES, MAX_CYCLES] are rejected. Good samples go into a
// 2^DEPTH_LOG2-deep ring buffer. The output is the newest sample while the
// buffer is filling, and the truncated running average once it is full.
// After STALE_LIMIT consecutive rejects, stale is raised and the buffer is
// flushed. out_cycles keeps its last good value so the display does not blank.
//
// Handshake: in_valid is a one-cycle strobe with no back-pressure. A strobe is
// taken only while busy is low. A strobe seen while busy is high is dropped
// without side effects. out_valid is a one-cycle pulse that marks a new
// out_cycles value.
//
// Ports:
//   clk, reset         12 MHz clock; synchronous active-high reset
//   in_cycles/in_valid raw echo width and its strobe
//   out_cycles         filtered width (held between updates)
//   out_valid          pulse when out_cycles updates
//   stale              high after STALE_LIMIT consecutive rejects
//   fill_count         number of good samples buffered, 0..2^DEPTH_LOG2
//   busy               high while a sample is being processed
module echo_smoother #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_LOG2  = 2,
  parameter int MIN_CYCLES  = 1800,
  parameter int MAX_CYCLES  = 360000,
  parameter int STALE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_cycles,
  input  logic                  in_valid,
  output logic [WIDTH-1:0]      out_cycles,
  output logic                  out_valid,
  output logic                  stale,
  output logic [DEPTH_LOG2:0]   fill_count,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SUM_W = WIDTH + DEPTH_LOG2;
  localparam int REJ_W = $clog2(STALE_LIMIT + 1);
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [REJ_W-1:0]    REJ_LIMIT  = REJ_W'(STALE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // state is left as a named signal so checkers can bind to it directly.
  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]      sample_q;
  logic [WIDTH-1:0]      sample_buf [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]      sum;
  logic [REJ_W-1:0]      rej_count;

  logic                  accept;
  logic                  full;
  logic [WIDTH-1:0]      evicted;
  logic [SUM_W-1:0]      sum_next;
  logic [DEPTH_LOG2:0]   fill_next;
  logic [REJ_W-1:0]      rej_next;
  logic [SUM_W-1:0]      avg_wide;

  // Datapath for the UPDATE cycle
  always_comb begin
    accept    = (sample_q >= WIDTH'(MIN_CYCLES)) && (sample_q <= WIDTH'(MAX_CYCLES));
    full      = (fill_count == FULL_COUNT);
    // The slot about to be overwritten holds the oldest sample only once the
    // ring is full. Before that, the slot holds nothing that belongs in the sum.
    evicted   = full ? sample_buf[wr_ptr] : '0;
    sum_next  = sum + SUM_W'(sample_q) - SUM_W'(evicted);
    fill_next = full ? fill_count : fill_count + (DEPTH_LOG2 + 1)'(1);
    rej_next  = (rej_count == REJ_LIMIT) ? rej_count : rej_count + REJ_W'(1);
    avg_wide  = sum_next >> DEPTH_LOG2;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = UPDATE;
      UPDATE:  state_next = EMIT;
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sample_q   <= '0;
      wr_ptr     <= '0;
      sum        <= '0;
      rej_count  <= '0;
      fill_count <= '0;
      stale      <= 1'b0;
      out_cycles <= '0;
      out_valid  <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) sample_q <= in_cycles;
        end
        UPDATE: begin
          if (accept) begin
            wr_ptr     <= wr_ptr + DEPTH_LOG2'(1);
            sum        <= sum_next;
            fill_count <= fill_next;
            rej_count  <= '0;
            stale      <= 1'b0;
            // Registered here so the pulse and value are visible during EMIT.
            out_valid  <= 1'b1;
            out_cycles <= (fill_next == FULL_COUNT) ? WIDTH'(avg_wide) : sample_q;
          end else begin
            rej_count <= rej_next;
            if (rej_next == REJ_LIMIT) begin
              stale      <= 1'b1;
              fill_count <= '0;
              sum        <= '0;
              wr_ptr     <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The sample storage has no reset. Slots are only read for eviction once
  // fill_count says they hold valid data.
  always_ff @(posedge clk) begin
    if (!reset && state == UPDATE && accept) sample_buf[wr_ptr] <= sample_q;
  end

endmodule

// File: tb/tb_echo_smoother.sv
module tb_echo_smoother;
  localparam int WIDTH = 32;
  localparam int DL    = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_cycles = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] out_cycles;
  logic             out_valid;
  logic             stale;
  logic [DL:0]      fill_count;
  logic             busy;

  echo_smoother #(
    .WIDTH(WIDTH), .DEPTH_LOG2(DL), .MIN_CYCLES(1800),
    .MAX_CYCLES(360000), .STALE_LIMIT(8)
  ) dut (
    .clk(clk), .reset(reset), .in_cycles(in_cycles), .in_valid(in_valid),
    .out_cycles(out_cycles), .out_valid(out_valid), .stale(stale),
    .fill_count(fill_count), .busy(busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulse_count = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: list of good samples, reject run length, and a fixed
  // two-cycle latency from strobe to result.
  longint           m_q[$];
  int               m_rej = 0;
  bit               m_stale = 0;
  logic [WIDTH-1:0] m_out = '0;
  bit               m_valid = 0;
  int               m_wait = 0;
  logic [WIDTH-1:0] m_pending = '0;

  function automatic longint q_sum(input longint q[$]);
    longint s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_rej = 0; m_stale = 0; m_out = '0; m_valid = 0; m_wait = 0;
    end else begin
      m_valid = 0;
      if (m_wait == 2) begin
        m_wait = 1;
        if (m_pending >= 1800 && m_pending <= 360000) begin
          m_q.push_back(longint'(m_pending));
          if (m_q.size() > 4) void'(m_q.pop_front());
          m_rej = 0; m_stale = 0; m_valid = 1;
          m_out = (m_q.size() == 4) ? WIDTH'(q_sum(m_q) / 4) : m_pending;
        end else begin
          if (m_rej < 8) m_rej++;
          if (m_rej == 8) begin m_stale = 1; m_q.delete(); end
        end
      end else if (m_wait == 1) begin
        m_wait = 0;
      end else if (in_valid) begin
        m_wait = 2;
        m_pending = in_cycles;
      end
    end
  end

  // Scoreboard: every cycle against the model, and every pulse against the
  // hand-computed expected queue.
  always @(negedge clk) begin
    check("out_valid", out_valid, m_valid);
    check("out_cycles", out_cycles, m_out);
    check("stale", stale, m_stale);
    check("fill_count", fill_count, m_q.size());
    check("busy", busy, m_wait != 0);
    if (out_valid === 1'b1) begin
      pulse_count++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: got out_cycles=%0d expected no pulse", out_cycles);
      end else begin
        check("pulse_value", out_cycles, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [WIDTH-1:0] v, input bit exp_pulse, input logic [WIDTH-1:0] exp_v);
    if (exp_pulse) exp_q.push_back(exp_v);
    @(negedge clk); in_valid = 1'b1; in_cycles = v;
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_out", out_cycles, 0);
    check("reset_fill", fill_count, 0);
    check("reset_stale", stale, 0);
    check("reset_busy", busy, 0);

    // Fill phase: pass-through
    send(6000, 1, 6000);
    check("fill1_out", out_cycles, 6000);
    check("fill1_cnt", fill_count, 1);
    send(12000, 1, 12000);
    check("fill2_out", out_cycles, 12000);
    check("fill2_cnt", fill_count, 2);

    // Averaging and eviction
    do_reset();
    send(1000, 0, 0);
    check("low_reject_cnt", fill_count, 0);
    send(2000, 1, 2000);
    send(3000, 1, 3000);
    send(4000, 1, 4000);
    send(5000, 1, 3500);
    check("avg_out", out_cycles, 3500);
    check("avg_cnt", fill_count, 4);
    send(9000, 1, 5250);
    check("evict_out", out_cycles, 5250);

    // Range boundaries
    send(1800, 1, 4950);      // 4000+5000+9000+1800
    send(360000, 1, 93950);   // 5000+9000+1800+360000
    send(1799, 0, 0);
    check("below_min_out", out_cycles, 93950);
    send(360001, 0, 0);
    check("above_max_out", out_cycles, 93950);
    check("above_max_cnt", fill_count, 4);

    // Stale: clear the reject run, then 8 zeros
    send(6000, 1, 94200);     // 9000+1800+360000+6000
    for (int i = 0; i < 7; i++) send(0, 0, 0);
    check("seven_rejects_stale", stale, 0);
    check("seven_rejects_cnt", fill_count, 4);
    send(0, 0, 0);
    check("stale_set", stale, 1);
    check("stale_flush", fill_count, 0);
    check("stale_hold_out", out_cycles, 94200);
    send(12000, 1, 12000);
    check("stale_clear", stale, 0);
    check("recover_out", out_cycles, 12000);

    // 7 rejects then a good sample: stale never asserts
    for (int i = 0; i < 7; i++) send(0, 0, 0);
    send(3000, 1, 3000);
    check("seven_then_good_stale", stale, 0);
    check("seven_then_good_cnt", fill_count, 2);

    // Busy drop: back-to-back strobes
    do_reset();
    pc = pulse_count;
    exp_q.push_back(6000);
    @(negedge clk); in_valid = 1'b1; in_cycles = 6000;
    @(negedge clk); in_cycles = 24000;
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_drop_out", out_cycles, 6000);
    check("busy_drop_cnt", fill_count, 1);
    check("busy_drop_pulses", pulse_count - pc, 1);

    // Reset during UPDATE
    pc = pulse_count;
    @(negedge clk); in_valid = 1'b1; in_cycles = 12000;
    @(negedge clk); in_valid = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("rst_upd_out", out_cycles, 0);
    check("rst_upd_cnt", fill_count, 0);
    check("rst_upd_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("rst_upd_pulses", pulse_count - pc, 0);

    // Reset and strobe in the same cycle: reset wins
    @(negedge clk); reset = 1'b1; in_valid = 1'b1; in_cycles = 6000;
    @(negedge clk); reset = 1'b0; in_valid = 1'b0;
    check("rst_strobe_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("rst_strobe_cnt", fill_count, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
